// File: rtl/gdbte_wb_arbiter.sv
// ----------------------------------------------------------------------------
// gdbte_wb_arbiter
//
// Two-master Wishbone arbiter that shares one slave bus between the CPU data
// port (master 0) and the GDB target engine (master 1). A grant is held for
// the whole Wishbone cycle (cyc), so multi-beat accesses are never split.
// Ties go to the GDB engine (PRIO_GDB=1) or alternate round-robin
// (PRIO_GDB=0).
//
// Optional feature, enabled by defining GDBTE_WB_ARB_TIMEOUT_EN:
//   a per-grant watchdog aborts a cycle after TIMEOUT strobed cycles without
//   an ack, pulses the owner's err for one cycle and parks the slave bus in
//   ABORT until the owner drops cyc. Without the macro the err outputs are
//   tied low and a missing ack stalls the bus.
//
// Parameters:
//   AW, DW    address / data width (DW must be a multiple of 8)
//   PRIO_GDB  1 = master 1 wins ties, 0 = round-robin
//   TIMEOUT   strobed cycles without ack before abort (feature only)
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-low reset
//   m0_* (in)                 CPU master cyc/stb/we/adr/dat/sel
//   m0_dat_o/ack_o/err_o      read data, ack, timeout error to the CPU
//   m1_*                      same set for the GDB engine
//   s_*_o                     muxed master signals towards the slave
//   s_dat_i, s_ack_i          slave read data and ack
//   gnt_o                     one-hot current grant {m1,m0}
// ----------------------------------------------------------------------------
module gdbte_wb_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int PRIO_GDB = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // master 0: CPU core
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  // master 1: GDB target engine
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  // shared slave bus
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  // status
  output logic [1:0]      gnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } state_e;

  state_e state_q, state_d;
  // Last-grant pointer: 0 = m0 was served last, 1 = m1 was served last.
  // In ABORT it also names the master whose cycle was aborted.
  logic   last_q, last_d;
  logic   timeout_hit;

  // Pick the next owner from the current requests. The pointer only matters
  // when both masters request in round-robin mode.
  function automatic state_e arbitrate(input logic req0, input logic req1,
                                       input logic last);
    state_e res;
    res = IDLE;
    if (req0 && req1) begin
      if (PRIO_GDB != 0) res = GNT1;
      else               res = last ? GNT0 : GNT1;
    end else if (req0) begin
      res = GNT0;
    end else if (req1) begin
      res = GNT1;
    end
    return res;
  endfunction

`ifdef GDBTE_WB_ARB_TIMEOUT_EN
  // At least 8 bits, wide enough to hold TIMEOUT itself.
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          granted;
  logic          own_cyc;

  always_comb begin
    granted     = (state_q == GNT0) || (state_q == GNT1);
    own_cyc     = (state_q == GNT1) ? m1_cyc_i : m0_cyc_i;
    // Only an owner still holding cyc can be aborted; a release in the same
    // cycle simply ends the transfer normally.
    timeout_hit = granted && own_cyc && (cnt_q == CW'(TIMEOUT));
  end

  always_comb begin
    cnt_d = cnt_q;
    // Any state change (grant entry, handover, abort, release) restarts the
    // count so every grant gets the full budget.
    if (!granted || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (s_ack_i) begin
      cnt_d = '0;
    end else if (s_stb_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
  // TIMEOUT only sizes the watchdog; keep it referenced in this build.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  // --------------------------------------------------------------------------
  // Grant FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values that were present before the clock edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;   // m0 wins the first tie after reset
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Grant FSM: next state
  // --------------------------------------------------------------------------
  // NOTE: every variable written in a combinational block gets a default at
  // the top; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        state_d = arbitrate(m0_cyc_i, m1_cyc_i, last_q);
      end
      GNT0: begin
        if (timeout_hit) begin
          state_d = ABORT;
          last_d  = 1'b0;
        end else if (!m0_cyc_i) begin
          // Release: hand straight over to a waiting master, no idle cycle.
          last_d  = 1'b0;
          state_d = arbitrate(1'b0, m1_cyc_i, 1'b0);
        end
      end
      GNT1: begin
        if (timeout_hit) begin
          state_d = ABORT;
          last_d  = 1'b1;
        end else if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = arbitrate(m0_cyc_i, 1'b0, 1'b1);
        end
      end
      ABORT: begin
        // Park the bus until the aborted master acknowledges by dropping cyc.
        if (!(last_q ? m1_cyc_i : m0_cyc_i)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output mux: purely combinational from the state and the owner's inputs,
  // so an asynchronous reset drops the slave strobes immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    gnt_o    = 2'b00;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    // Read data is broadcast; each master qualifies it with its own ack.
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    case (state_q)
      GNT0: begin
        s_cyc_o  = m0_cyc_i & ~timeout_hit;
        s_stb_o  = m0_stb_i & ~timeout_hit;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        gnt_o    = 2'b01;
        m0_ack_o = s_ack_i & ~timeout_hit;
        m0_err_o = timeout_hit;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i & ~timeout_hit;
        s_stb_o  = m1_stb_i & ~timeout_hit;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        gnt_o    = 2'b10;
        m1_ack_o = s_ack_i & ~timeout_hit;
        m1_err_o = timeout_hit;
      end
      default: begin
        // IDLE / ABORT: slave bus idle, stray slave acks are not forwarded.
      end
    endcase
  end

endmodule

// File: tb/tb_gdbte_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_gdbte_wb_arbiter
//
// Self-checking bench for gdbte_wb_arbiter. Two instances share the stimulus:
// u_rr (round-robin) and u_pr (GDB priority). Single transfers come from a
// vector table through a scoreboard queue; ties, grant hold, timeout (when
// GDBTE_WB_ARB_TIMEOUT_EN is defined) and async reset are hand sequences.
// ----------------------------------------------------------------------------
module tb_gdbte_wb_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_dat, m1_dat, s_dat;
  logic [SW-1:0] m0_sel, m1_sel;
  logic          s_ack;

  logic [DW-1:0] rr_m0_dat, rr_m1_dat, rr_s_dat, pr_m0_dat, pr_m1_dat, pr_s_dat;
  logic          rr_m0_ack, rr_m0_err, rr_m1_ack, rr_m1_err;
  logic          pr_m0_ack, pr_m0_err, pr_m1_ack, pr_m1_err;
  logic          rr_s_cyc, rr_s_stb, rr_s_we, pr_s_cyc, pr_s_stb, pr_s_we;
  logic [AW-1:0] rr_s_adr, pr_s_adr;
  logic [SW-1:0] rr_s_sel, pr_s_sel;
  logic [1:0]    rr_gnt, pr_gnt;

  always #5 clk = ~clk;

  gdbte_wb_arbiter #(.AW(AW), .DW(DW), .PRIO_GDB(0), .TIMEOUT(TMO)) u_rr (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(rr_m0_dat),
    .m0_ack_o(rr_m0_ack), .m0_err_o(rr_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(rr_m1_dat),
    .m1_ack_o(rr_m1_ack), .m1_err_o(rr_m1_err),
    .s_cyc_o(rr_s_cyc), .s_stb_o(rr_s_stb), .s_we_o(rr_s_we),
    .s_adr_o(rr_s_adr), .s_dat_o(rr_s_dat), .s_sel_o(rr_s_sel),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .gnt_o(rr_gnt)
  );

  gdbte_wb_arbiter #(.AW(AW), .DW(DW), .PRIO_GDB(1), .TIMEOUT(TMO)) u_pr (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(pr_m0_dat),
    .m0_ack_o(pr_m0_ack), .m0_err_o(pr_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(pr_m1_dat),
    .m1_ack_o(pr_m1_ack), .m1_err_o(pr_m1_err),
    .s_cyc_o(pr_s_cyc), .s_stb_o(pr_s_stb), .s_we_o(pr_s_we),
    .s_adr_o(pr_s_adr), .s_dat_o(pr_s_dat), .s_sel_o(pr_s_sel),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .gnt_o(pr_gnt)
  );

  typedef struct {
    logic          who;      // 0 = m0, 1 = m1
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [SW-1:0] sel;
    logic [DW-1:0] rdat;     // slave read data returned with the ack
    logic [1:0]    exp_gnt;
  } vec_t;

  vec_t vecs[6];
  vec_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_masters();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
    s_ack = 0; s_dat = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0;
    idle_masters();
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  // One single-beat transfer from the vector table, checked at the slave side
  // against the scoreboard entry and at the master side on the ack.
  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    int   waits;
    logic seen;
    @(negedge clk);
    if (!v.who) begin
      m0_cyc = 1; m0_stb = 1; m0_we = v.we; m0_adr = v.adr; m0_dat = v.wdat; m0_sel = v.sel;
    end else begin
      m1_cyc = 1; m1_stb = 1; m1_we = v.we; m1_adr = v.adr; m1_dat = v.wdat; m1_sel = v.sel;
    end
    sb_q.push_back(v);
    #1 check($sformatf("v%0d_cyc_before_grant", idx), rr_s_cyc, 0);
    waits = 0;
    seen  = 1'b0;
    while (!seen && waits < 8) begin
      @(negedge clk); #1;
      waits++;
      seen = rr_s_cyc;
    end
    check($sformatf("v%0d_grant_latency", idx), waits, 1);
    e = sb_q.pop_front();
    if (seen) begin
      check($sformatf("v%0d_s_adr", idx), rr_s_adr, e.adr);
      check($sformatf("v%0d_s_we",  idx), rr_s_we,  e.we);
      check($sformatf("v%0d_s_dat", idx), rr_s_dat, e.wdat);
      check($sformatf("v%0d_s_sel", idx), rr_s_sel, e.sel);
      check($sformatf("v%0d_gnt",   idx), rr_gnt,   e.exp_gnt);
      s_dat = e.rdat;
      s_ack = 1'b1;
      #1;
      check($sformatf("v%0d_own_ack",   idx), e.who ? rr_m1_ack : rr_m0_ack, 1);
      check($sformatf("v%0d_other_ack", idx), e.who ? rr_m0_ack : rr_m1_ack, 0);
      check($sformatf("v%0d_rdata",     idx), e.who ? rr_m1_dat : rr_m0_dat, e.rdat);
    end
    @(negedge clk);
    idle_masters();
    @(negedge clk);
    #1 check($sformatf("v%0d_idle_after", idx), rr_gnt, 2'b00);
  endtask

  // Both masters request continuously; each owner takes one ack, releases for
  // a cycle and re-requests. Expected grant order comes from the tie rule for
  // the first grant, then strict alternation on release.
  task automatic alt_seq(input bit use_pr, input int n);
    logic exp_q[$];
    logic x;
    logic e;
    x = use_pr ? 1'b1 : 1'b0;   // pointer is m1 after reset
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(x);
      x = ~x;
    end
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_1000;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_2000;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      #1 check($sformatf("%s_gnt%0d", use_pr ? "prio" : "rr", i),
               use_pr ? pr_gnt : rr_gnt, e ? 2'b10 : 2'b01);
      s_ack = 1'b1;
      s_dat = 32'(i);
      #1;
      check($sformatf("%s_own_ack%0d", use_pr ? "prio" : "rr", i),
            e ? (use_pr ? pr_m1_ack : rr_m1_ack) : (use_pr ? pr_m0_ack : rr_m0_ack), 1);
      check($sformatf("%s_oth_ack%0d", use_pr ? "prio" : "rr", i),
            e ? (use_pr ? pr_m0_ack : rr_m0_ack) : (use_pr ? pr_m1_ack : rr_m1_ack), 0);
      @(negedge clk);
      s_ack = 1'b0;
      if (e) begin m1_cyc = 0; m1_stb = 0; end
      else   begin m0_cyc = 0; m0_stb = 0; end
      #1 check($sformatf("%s_rel_cyc%0d", use_pr ? "prio" : "rr", i),
               use_pr ? pr_s_cyc : rr_s_cyc, 0);
      @(negedge clk);
      if (i != n - 1) begin
        if (e) begin m1_cyc = 1; m1_stb = 1; end
        else   begin m0_cyc = 1; m0_stb = 1; end
      end
    end
    idle_masters();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic last_m;
    logic exp_rr;
    int   k;
    logic found;

    vecs[0] = '{who: 1'b0, we: 1'b0, adr: 32'h0000_0100, wdat: 32'h0,
                sel: 4'hF, rdat: 32'hDEAD_BEEF, exp_gnt: 2'b01};
    vecs[1] = '{who: 1'b1, we: 1'b1, adr: 32'h0000_2000, wdat: 32'h1234_5678,
                sel: 4'h3, rdat: 32'h0BAD_F00D, exp_gnt: 2'b10};
    vecs[2] = '{who: 1'b0, we: 1'b1, adr: 32'hFFFF_FFFC, wdat: 32'hA5A5_5A5A,
                sel: 4'h8, rdat: 32'h0, exp_gnt: 2'b01};
    vecs[3] = '{who: 1'b1, we: 1'b0, adr: 32'h0000_0000, wdat: 32'h0,
                sel: 4'hF, rdat: 32'h0, exp_gnt: 2'b10};
    vecs[4] = '{who: 1'b1, we: 1'b0, adr: 32'h8000_0000, wdat: 32'hCAFE_0001,
                sel: 4'h1, rdat: 32'hFFFF_FFFF, exp_gnt: 2'b10};
    vecs[5] = '{who: 1'b0, we: 1'b1, adr: 32'h0000_0044, wdat: 32'h0000_0000,
                sel: 4'h0, rdat: 32'h7777_7777, exp_gnt: 2'b01};

    // ---- reset with random, active-looking inputs ----
    rst_i  = 1'b0;
    m0_cyc = 1; m0_stb = 1'($urandom); m0_we = 1'($urandom);
    m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'($urandom);
    m1_cyc = 1; m1_stb = 1'($urandom); m1_we = 1'($urandom);
    m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom);
    s_ack  = 1; s_dat = $urandom;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt_rr",   rr_gnt,    2'b00);
    check("rst_gnt_pr",   pr_gnt,    2'b00);
    check("rst_s_cyc",    rr_s_cyc,  0);
    check("rst_s_adr",    rr_s_adr,  0);
    check("rst_m0_ack",   rr_m0_ack, 0);
    check("rst_m1_ack",   rr_m1_ack, 0);
    idle_masters();
    @(negedge clk);
    rst_i = 1'b1;

    // ---- table-driven single transfers ----
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // ---- ties from IDLE: round-robin alternates, priority always m1 ----
    do_reset();
    last_m = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      exp_rr = ~last_m;
      last_m = exp_rr;
      @(negedge clk);
      #1;
      check($sformatf("tie%0d_rr_gnt", t), rr_gnt, exp_rr ? 2'b10 : 2'b01);
      check($sformatf("tie%0d_pr_gnt", t), pr_gnt, 2'b10);
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      @(negedge clk);
      #1 check($sformatf("tie%0d_idle", t), rr_gnt, 2'b00);
    end

    // ---- back-to-back handover: round-robin and GDB priority ----
    do_reset();
    alt_seq(1'b0, 8);
    do_reset();
    alt_seq(1'b1, 6);

    // ---- grant hold: m0 burst of 4 acks while m1 waits ----
    do_reset();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0300;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0400;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      #1 check($sformatf("hold_gnt%0d", b), rr_gnt, 2'b01);
      s_ack = 1'b1;
      #1;
      check($sformatf("hold_m0_ack%0d", b), rr_m0_ack, 1);
      check($sformatf("hold_m1_ack%0d", b), rr_m1_ack, 0);
      @(negedge clk);
    end
    s_ack = 1'b0;
    m0_cyc = 0; m0_stb = 0;
    #1 check("hold_rel_gnt", rr_gnt, 2'b01);
    @(negedge clk);
    #1 check("hold_handover_gnt", rr_gnt, 2'b10);
    idle_masters();
    @(negedge clk);
    @(negedge clk);

`ifdef GDBTE_WB_ARB_TIMEOUT_EN
    // ---- timeout: m1 write to a slave that never acks ----
    do_reset();
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h0000_2000; m1_dat = 32'h5555_AAAA; m1_sel = 4'hF;
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0010;
    #1 check("tmo_stb_rise", rr_s_stb, 1);
    k = 0;
    found = 1'b0;
    while (!found && k < 40) begin
      @(negedge clk); #1;
      k++;
      found = rr_m1_err;
    end
    check("tmo_err_delay", k, TMO);
    check("tmo_err_cyc_forced", rr_s_cyc, 0);
    check("tmo_err_m0", rr_m0_err, 0);
    @(negedge clk); #1;
    check("tmo_err_one_cycle", rr_m1_err, 0);
    check("tmo_abort_gnt", rr_gnt, 2'b00);
    found = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      if (rr_s_cyc) found = 1'b1;
    end
    check("tmo_abort_cyc_low", found, 0);
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    k = 0;
    found = 1'b0;
    while (!found && k < 6) begin
      @(negedge clk); #1;
      k++;
      found = (rr_gnt == 2'b01);
    end
    check("tmo_m0_after_abort", k, 2);
    idle_masters();
    @(negedge clk);
    @(negedge clk);
`endif

    // ---- asynchronous reset between burst beats ----
    do_reset();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0500;
    @(negedge clk);
    s_ack = 1'b1;
    #1 check("arst_first_ack", rr_m0_ack, 1);
    @(negedge clk);
    s_ack = 1'b0;
    #1 check("arst_cyc_before", rr_s_cyc, 1);
    #1 rst_i = 1'b0;
    #1;
    check("arst_s_cyc", rr_s_cyc, 0);
    check("arst_gnt",   rr_gnt,   2'b00);
    s_ack = 1'b1;
    #1 check("arst_no_ack", rr_m0_ack, 0);
    @(negedge clk);
    idle_masters();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gdbte_wb_arbiter.md
Name: gdbte_wb_arbiter

Overview:
- Two-master Wishbone arbiter that shares one slave bus (memory/IO) between the CPU core (master 0) and the GDB target engine (master 1).
- Sits between the core's data port, the GDB engine's Wishbone master port and the system slave interconnect.
- Lets the debugger peek and poke memory while the CPU runs or is halted.
- Round-robin or fixed GDB priority; grant is held for the whole cycle (cyc_i), so multi-beat accesses are never split.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- PRIO_GDB, 0: 1 = master 1 always wins a tie; 0 = round-robin.
- TIMEOUT, 255: cycles without ack before abort (only with the optional feature).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-low
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  CPU master controls
- m0_adr_i  in  AW  CPU address
- m0_dat_i  in  DW  CPU write data
- m0_sel_i  in  DW/8  CPU byte selects
- m0_dat_o  out  DW  read data to CPU
- m0_ack_o  out  1  ack to CPU
- m0_err_o  out  1  timeout error to CPU
- m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i, m1_dat_o, m1_ack_o, m1_err_o  same as m0, for the GDB engine
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_sel_o  out  DW/8  slave byte selects
- s_dat_i  in  DW  slave read data
- s_ack_i  in  1  slave ack
- gnt_o  out  2  one-hot current grant {m1,m0}; debug/status

Behaviour:
- States: IDLE, GNT0, GNT1, ABORT. The state register is the only grant storage.
- Reset (rst_i low, asynchronous): state IDLE, last-grant pointer = m1 (so m0 wins the first tie), timeout counter 0.
- All outputs are combinational from state plus muxed inputs. In IDLE/ABORT: s_cyc_o = s_stb_o = s_we_o = 0, s_adr_o/s_dat_o/s_sel_o = 0, both acks/errs 0, gnt_o = 00.
- Arbitration function (used in IDLE and on release):
  - only one cyc_i high: grant it;
  - both high: PRIO_GDB=1 gives m1; otherwise grant the master not equal to the last-grant pointer.
- Request-to-grant latency: master raises cyc_i in cycle N while IDLE; GNTx is registered at edge N+1, so slave signals are driven from cycle N+1.
- GNTx:
  - s_* outputs follow master x combinationally: s_cyc_o = mx_cyc_i, s_stb_o = mx_stb_i, etc.
  - gnt_o bit x = 1.
  - mx_ack_o = s_ack_i; the non-granted master's ack/err = 0.
  - m0_dat_o = m1_dat_o = s_dat_i, broadcast; valid only with the own ack.
  - Non-granted master's stb is ignored; it simply waits.
- Release: when mx_cyc_i = 0 in GNTx, the pointer updates to x and the next state comes from the arbitration function on current requests. Direct handover, zero idle cycles; IDLE if no requests.
- Grant is never revoked while cyc_i stays high, except by timeout.
- Simultaneous release by x and request by y in the same cycle: y granted next edge.
- Both requesting from IDLE in the same cycle: tie rule applies.
- s_ack_i while IDLE/ABORT: ignored, no master ack.
- Reset mid-transaction: immediate IDLE, all slave strobes drop asynchronously.

Optional Feature:
- Macro GDBTE_WB_ARB_TIMEOUT_EN.
- Defined:
  - 8-bit-or-wider counter clears on grant entry and on every s_ack_i.
  - Increments each cycle s_stb_o=1 && s_ack_i=0.
  - When it reaches TIMEOUT: mx_err_o = 1 for exactly that cycle, s_cyc_o/s_stb_o forced 0 that cycle, next state ABORT.
  - ABORT holds the slave idle until mx_cyc_i = 0, then IDLE, pointer = x.
  - This prevents a hung slave from locking the debugger out.
- Undefined: no counter, ABORT unreachable, m0_err_o = m1_err_o = 0 constant; a missing ack stalls forever.

Test Plan:
- Reset: rst_i low with random inputs -> gnt_o=00, s_cyc_o=0. Release reset, m0 single read @0x100, slave acks 1 cycle later with 0xDEADBEEF -> s_cyc_o rises one cycle after m0_cyc_i, m0_ack_o with m0_dat_o=0xDEADBEEF, m1_ack_o=0.
- Tie, round-robin (PRIO_GDB=0): both raise cyc in the same cycle, four back-to-back cycles each -> grant order m0,m1,m0,m1; handover with no IDLE cycle between.
- PRIO_GDB=1 tie: both request continuously -> m1 always granted on release; m0 granted only when m1_cyc_i=0.
- Grant hold: m0 burst of 4 acks with m1 requesting throughout -> m1 sees no ack and gnt_o=01 until m0_cyc_i falls, then gnt_o=10 next cycle.
- Timeout (macro on, TIMEOUT=16): m1 write @0x2000, slave never acks -> m1_err_o pulses 1 cycle, 16 cycles after s_stb_o rose; s_cyc_o low thereafter; m0 granted after m1 drops cyc.
- Async reset mid-burst: assert rst_i low between acks -> s_cyc_o low before the next clock edge; no spurious ack.
